// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single write port of the 32x32 register bank between the ALU
// result path (requester 0) and the load path (requester 1). Each requester
// hands a write into its own one-entry holding buffer through a valid/ready
// handshake. A round-robin arbiter moves one buffered write per cycle into a
// registered output stage that drives the bank. Read-after-write hazards are
// flagged against every write still in flight (both buffers and the output
// stage).
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   alu_valid/addr/data     requester 0 write offer
//   alu_ready               requester 0 handshake accept
//   ld_valid/addr/data      requester 1 write offer
//   ld_ready                requester 1 handshake accept
//   rf_we/waddr/wdata       registered bank write port
//   rd_addr_1, rd_addr_2    decode-stage source registers
//   raw_stall               combinational hazard flag
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,

    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic              raw_stall
);

    // Holding buffers
    logic              buf0_valid_q, buf0_valid_d;
    logic [ADDR_W-1:0] buf0_addr_q,  buf0_addr_d;
    logic [DATA_W-1:0] buf0_data_q,  buf0_data_d;
    logic              buf1_valid_q, buf1_valid_d;
    logic [ADDR_W-1:0] buf1_addr_q,  buf1_addr_d;
    logic [DATA_W-1:0] buf1_data_q,  buf1_data_d;

    // Round-robin pointer: 0 favours ALU, 1 favours load, when both are full
    logic              rr_ptr_q, rr_ptr_d;

    // Output stage
    logic              rf_we_q,    rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic grant0, grant1;
    logic both_full;
    logic alu_zero, ld_zero;
    logic alu_take, ld_take;

    // Arbitration and handshake
    always_comb begin
        both_full = buf0_valid_q & buf1_valid_q;
        grant0    = buf0_valid_q & (~buf1_valid_q | ~rr_ptr_q);
        grant1    = buf1_valid_q & (~buf0_valid_q |  rr_ptr_q);

        // Writes to r0 are swallowed at the handshake: always ready, never stored.
        alu_zero  = (alu_addr == '0);
        ld_zero   = (ld_addr  == '0);

        alu_ready = ~buf0_valid_q | grant0 | alu_zero;
        ld_ready  = ~buf1_valid_q | grant1 | ld_zero;

        alu_take  = alu_valid & alu_ready & ~alu_zero;
        ld_take   = ld_valid  & ld_ready  & ~ld_zero;
    end

    // Next-state for buffers, pointer and output stage
    always_comb begin
        buf0_valid_d = buf0_valid_q;
        buf0_addr_d  = buf0_addr_q;
        buf0_data_d  = buf0_data_q;
        buf1_valid_d = buf1_valid_q;
        buf1_addr_d  = buf1_addr_q;
        buf1_data_d  = buf1_data_q;
        rr_ptr_d     = rr_ptr_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;

        // A simultaneous drain and refill keeps the buffer occupied.
        if (alu_take) begin
            buf0_valid_d = 1'b1;
            buf0_addr_d  = alu_addr;
            buf0_data_d  = alu_data;
        end else if (grant0) begin
            buf0_valid_d = 1'b0;
        end

        if (ld_take) begin
            buf1_valid_d = 1'b1;
            buf1_addr_d  = ld_addr;
            buf1_data_d  = ld_data;
        end else if (grant1) begin
            buf1_valid_d = 1'b0;
        end

        // Every cycle with both buffers full produces a grant, so toggle.
        if (both_full) begin
            rr_ptr_d = ~rr_ptr_q;
        end

        if (grant0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = buf0_addr_q;
            rf_wdata_d = buf0_data_q;
        end else if (grant1) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = buf1_addr_q;
            rf_wdata_d = buf1_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf0_valid_q <= 1'b0;
            buf0_addr_q  <= '0;
            buf0_data_q  <= '0;
            buf1_valid_q <= 1'b0;
            buf1_addr_q  <= '0;
            buf1_data_q  <= '0;
            rr_ptr_q     <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            buf0_valid_q <= buf0_valid_d;
            buf0_addr_q  <= buf0_addr_d;
            buf0_data_q  <= buf0_data_d;
            buf1_valid_q <= buf1_valid_d;
            buf1_addr_q  <= buf1_addr_d;
            buf1_data_q  <= buf1_data_d;
            rr_ptr_q     <= rr_ptr_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // Hazard detection against all in-flight writes; r0 never stalls.
    function automatic logic pending_hit(input logic [ADDR_W-1:0] a);
        logic hit;
        hit = (buf0_valid_q & (buf0_addr_q == a))
            | (buf1_valid_q & (buf1_addr_q == a))
            | (rf_we_q      & (rf_waddr_q  == a));
        return (a != '0) & hit;
    endfunction

    always_comb begin
        raw_stall = pending_hit(rd_addr_1) | pending_hit(rd_addr_2);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rd_addr_1;
    logic [4:0]  rd_addr_2;
    logic        raw_stall;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rd_addr_1 (rd_addr_1),
        .rd_addr_2 (rd_addr_2),
        .raw_stall (raw_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: each requester owns a pending slot; when both slots
    // hold a write, the requester whose turn it is goes first and the turn
    // passes to the other one. The bank port shows what was granted last cycle.
    bit          m_pend[2];
    logic [4:0]  m_paddr[2];
    logic [31:0] m_pdata[2];
    bit          m_turn_ld;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    logic [4:0]  wr_q[$];
    bit          last_alu_acc;
    bit          last_ld_acc;

    task automatic m_clear();
        m_pend[0] = 0; m_pend[1] = 0;
        m_paddr[0] = '0; m_paddr[1] = '0;
        m_pdata[0] = '0; m_pdata[1] = '0;
        m_turn_ld = 0;
        m_we = 0; m_wa = '0; m_wd = '0;
    endtask

    function automatic int m_winner();
        if (m_pend[0] && m_pend[1]) return m_turn_ld ? 1 : 0;
        if (m_pend[0]) return 0;
        if (m_pend[1]) return 1;
        return -1;
    endfunction

    function automatic bit m_ready(int k, logic [4:0] a);
        return (a == 5'd0) || !m_pend[k] || (m_winner() == k);
    endfunction

    function automatic bit m_hit(logic [4:0] a);
        if (a == 5'd0) return 0;
        return (m_pend[0] && m_paddr[0] == a) || (m_pend[1] && m_paddr[1] == a)
            || (m_we && m_wa == a);
    endfunction

    task automatic m_edge();
        int w;
        bit r0, r1;
        w  = m_winner();
        r0 = m_ready(0, alu_addr);
        r1 = m_ready(1, ld_addr);
        if (w >= 0) begin
            m_we = 1;
            m_wa = m_paddr[w];
            m_wd = m_pdata[w];
            if (m_pend[0] && m_pend[1]) m_turn_ld = !m_turn_ld;
            m_pend[w] = 0;
        end else begin
            m_we = 0;
        end
        if (alu_valid && r0 && alu_addr != 5'd0) begin
            m_pend[0] = 1; m_paddr[0] = alu_addr; m_pdata[0] = alu_data;
        end
        if (ld_valid && r1 && ld_addr != 5'd0) begin
            m_pend[1] = 1; m_paddr[1] = ld_addr; m_pdata[1] = ld_data;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check combinational outputs against the model with the
    // current inputs, clock, advance the model, check the bank port.
    task automatic step();
        #1;
        chk("alu_ready", 32'(alu_ready), 32'(m_ready(0, alu_addr)));
        chk("ld_ready",  32'(ld_ready),  32'(m_ready(1, ld_addr)));
        chk("raw_stall", 32'(raw_stall), 32'(m_hit(rd_addr_1) || m_hit(rd_addr_2)));
        last_alu_acc = alu_valid && alu_ready;
        last_ld_acc  = ld_valid && ld_ready;
        @(posedge clk);
        m_edge();
        #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(m_wa));
        chk("rf_wdata", rf_wdata, m_wd);
        if (rf_we) wr_q.push_back(rf_waddr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        #1;
        m_clear();
        chk("rst_async_we", 32'(rf_we), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int ai, li, we_cnt;
        int exp_order[8];
        exp_order = '{1, 11, 2, 12, 3, 13, 4, 14};

        reset = 1'b1;
        alu_valid = 0; alu_addr = '0; alu_data = '0;
        ld_valid  = 0; ld_addr  = '0; ld_data  = '0;
        rd_addr_1 = '0; rd_addr_2 = '0;
        last_alu_acc = 0; last_ld_acc = 0;
        m_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        #1;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_stall", 32'(raw_stall), 32'd0);

        // Single ALU write
        alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 0;
        step();
        chk("single_we", 32'(rf_we), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        chk("single_we_off", 32'(rf_we), 32'd0);

        // Full contention from reset
        do_reset();
        wr_q.delete();
        ai = 0; li = 0;
        for (int c = 0; c < 12; c++) begin
            alu_valid = (ai < 4); alu_addr = 5'(ai + 1);  alu_data = 32'hA000 + 32'(ai);
            ld_valid  = (li < 4); ld_addr  = 5'(li + 11); ld_data  = 32'hB000 + 32'(li);
            #1;
            if (c >= 1 && c <= 6) begin
                chk("alt_alu_ready", 32'(alu_ready), 32'(c % 2 == 1));
                chk("alt_ld_ready",  32'(ld_ready),  32'(c % 2 == 0));
            end
            step();
            if (last_alu_acc) ai++;
            if (last_ld_acc) li++;
        end
        alu_valid = 0; ld_valid = 0;
        chk("order_len", 32'(wr_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++)
            chk("order_addr", 32'(wr_q[i]), 32'(exp_order[i]));

        // Address-0 load write is swallowed
        do_reset();
        ld_valid = 1; ld_addr = 5'd0; ld_data = 32'hFFFFFFFF;
        #1;
        chk("zero_ld_ready", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 0;
        step();
        chk("zero_no_we1", 32'(rf_we), 32'd0);
        step();
        chk("zero_no_we2", 32'(rf_we), 32'd0);
        alu_valid = 1; alu_addr = 5'd3; alu_data = 32'h33;
        ld_valid  = 1; ld_addr  = 5'd9; ld_data  = 32'h99;
        step();
        alu_valid = 0; ld_valid = 0;
        step();
        chk("zero_first_alu", 32'(rf_waddr), 32'd3);
        step();
        chk("zero_then_ld", 32'(rf_waddr), 32'd9);
        step();

        // Hazard tracking
        do_reset();
        rd_addr_1 = 5'd0; rd_addr_2 = 5'd7;
        alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h77;
        #1;
        chk("haz_before", 32'(raw_stall), 32'd0);
        step();
        alu_valid = 0;
        #1;
        chk("haz_buffered", 32'(raw_stall), 32'd1);
        step();
        #1;
        chk("haz_out_stage", 32'(raw_stall), 32'd1);
        step();
        #1;
        chk("haz_retired", 32'(raw_stall), 32'd0);
        alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h78;
        rd_addr_2 = 5'd0;
        step();
        alu_valid = 0;
        #1;
        chk("haz_rd_zero", 32'(raw_stall), 32'd0);
        rd_addr_1 = 5'd7;
        #1;
        chk("haz_rd1", 32'(raw_stall), 32'd1);
        step(); step();
        rd_addr_1 = 5'd0;

        // Reset with both buffers and output stage occupied
        do_reset();
        alu_valid = 1; alu_addr = 5'd2; alu_data = 32'h22;
        ld_valid  = 1; ld_addr  = 5'd12; ld_data = 32'h1212;
        step();
        step();
        chk("midrst_we_before", 32'(rf_we), 32'd1);
        reset = 1'b1;
        alu_valid = 0; ld_valid = 0;
        #1;
        m_clear();
        chk("midrst_we_now", 32'(rf_we), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_we", 32'(rf_we), 32'd0);
            chk("midrst_alu_ready", 32'(alu_ready), 32'd1);
            chk("midrst_ld_ready", 32'(ld_ready), 32'd1);
        end

        // ALU streaming with load idle
        do_reset();
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            alu_valid = (i < 8); alu_addr = 5'(i + 1); alu_data = $urandom;
            #1;
            if (i < 8) chk("stream_ready", 32'(alu_ready), 32'd1);
            step();
            if (rf_we) we_cnt++;
            if (i >= 1 && i <= 8) chk("stream_we", 32'(rf_we), 32'd1);
        end
        chk("stream_count", 32'(we_cnt), 32'd8);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            if (!alu_valid || last_alu_acc) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_addr  = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!ld_valid || last_ld_acc) begin
                ld_valid = ($urandom_range(0, 3) != 0);
                ld_addr  = 5'($urandom_range(0, 7));
                ld_data  = $urandom;
            end
            rd_addr_1 = 5'($urandom_range(0, 7));
            rd_addr_2 = 5'($urandom_range(0, 7));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
